// File: rtl/serial_addsub_acc.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub_acc
//  Brief    : Bit-serial adder/subtractor with accumulate; one bit per cycle,
//             LSB first, through a single full-adder slice.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_acc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             V,
    output logic             zero
);

    localparam int              c_IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_next;
    logic [c_IW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_v;
    logic             r_zero;
    logic             w_abit;
    logic             w_bbit;
    logic             w_s;
    logic             w_cnext;
    logic             w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_RUN;
            c_RUN:   if (r_idx == c_LAST) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Single full-adder slice; B is already inverted for subtraction.
    assign w_abit  = r_a[r_idx];
    assign w_bbit  = r_b[r_idx];
    assign w_s     = w_abit ^ w_bbit ^ r_carry;
    assign w_cnext = (w_abit & w_bbit) | (w_abit & r_carry) | (w_bbit & r_carry);
    assign w_last  = (r_state == c_RUN) && (r_idx == c_LAST);

    always_comb begin
        w_res_next        = r_res;
        w_res_next[r_idx] = w_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
            r_zero  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        // acc takes the result currently on sum, before any update.
                        r_a     <= acc ? r_sum : a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_res   <= '0;
                    end
                end
                c_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cnext;
                    r_idx   <= r_idx + c_IW'(1);
                    if (w_last) begin
                        // r_carry here is the carry into the MSB.
                        r_sum  <= w_res_next;
                        r_cout <= w_cnext;
                        r_v    <= r_carry ^ w_cnext;
                        r_zero <= (w_res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != c_IDLE);
    assign done = (r_state == c_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign V    = r_v;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_addsub_acc
//  Brief    : Self-checking bench for serial_addsub_acc against an arithmetic
//             reference model, directed vectors plus randomized operations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_acc;

    localparam int c_W = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic           sub;
    logic           acc;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] sum;
    logic           cout;
    logic           V;
    logic           zero;

    int total = 0;
    int bad   = 0;

    logic [c_W-1:0] m_sum;
    logic           m_cout;
    logic           m_v;

    serial_addsub_acc #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .acc   (acc),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .V     (V),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic s, input logic ac, input logic [c_W-1:0] av, input logic [c_W-1:0] bv);
        int opa;
        int opb;
        int full;
        int sa;
        int sb;
        int sr;
        opa  = ac ? int'(m_sum) : int'(av);
        opb  = int'(bv);
        full = s ? (opa + ((~opb) & 15) + 1) : (opa + opb);
        sa   = (opa >= 8) ? opa - 16 : opa;
        sb   = (opb >= 8) ? opb - 16 : opb;
        sr   = s ? sa - sb : sa + sb;
        m_sum  = full[c_W-1:0];
        m_cout = full[c_W];
        m_v    = (sr > 7) || (sr < -8);
    endtask

    task automatic do_op(input logic s, input logic ac, input logic [c_W-1:0] av,
                         input logic [c_W-1:0] bv, input bit noise);
        logic [c_W-1:0] prev;
        prev = m_sum;
        @(negedge clk);
        start = 1'b1; sub = s; acc = ac; a = av; b = bv;
        @(posedge clk);
        model(s, ac, av, bv);
        for (int k = 1; k <= c_W + 1; k++) begin
            #1;
            check("busy", busy, 1);
            check("done", done, (k == c_W + 1));
            if (k <= c_W) begin
                check("hold_sum", sum, prev);
            end else begin
                check("sum", sum, m_sum);
                check("cout", cout, m_cout);
                check("V", V, m_v);
                check("zero", zero, (m_sum == 0));
            end
            if (noise) begin
                start = 1'($urandom);
                sub   = 1'($urandom);
                acc   = 1'($urandom);
                a     = c_W'($urandom);
                b     = c_W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sub = 1'b0; acc = 1'b0; a = '0; b = '0;
        m_sum = '0; m_cout = 1'b0; m_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_V", V, 0);
        check("rst_zero", zero, 1);
        reset = 1'b0;

        // Directed vectors
        do_op(1'b0, 1'b0, 4'b0111, 4'b0001, 1'b0);
        do_op(1'b1, 1'b0, 4'b0011, 4'b0101, 1'b0);
        do_op(1'b1, 1'b0, 4'b0101, 4'b0011, 1'b0);
        do_op(1'b1, 1'b0, 4'b1000, 4'b0001, 1'b0);
        do_op(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b0);
        do_op(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0);
        do_op(1'b0, 1'b1, 4'b1111, 4'b0011, 1'b0);
        do_op(1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0);
        check("acc_chain", sum, 4'b1111);

        // Idle with start low holds everything
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = c_W'($urandom); b = c_W'($urandom); sub = 1'($urandom); acc = 1'($urandom);
            @(posedge clk);
            #1;
            check("idle_hold_busy", busy, 0);
            check("idle_hold_sum", sum, m_sum);
        end

        // Mid-operation input noise and restart attempts
        do_op(1'b0, 1'b0, 4'b0110, 4'b0101, 1'b1);

        // Reset mid-RUN aborts with no done pulse
        @(negedge clk);
        start = 1'b1; sub = 1'b0; acc = 1'b0; a = 4'd3; b = 4'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_zero", zero, 1);
        reset = 1'b0;
        m_sum = '0;
        for (int i = 0; i < c_W + 2; i++) begin
            @(posedge clk);
            #1;
            check("abort_nodone", done, 0);
        end
        do_op(1'b0, 1'b0, 4'd3, 4'd4, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 1'($urandom), c_W'($urandom), c_W'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_addsub_acc.md
SERIAL_ADDSUB_ACC -- requirements
Module: serial_addsub_acc

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand/result width in bits (legal 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: sub  input  1  0 = A+B, 1 = A-B (two's complement: invert B, carry-in 1).
REQ-006 SHALL have port: acc  input  1  1 = use current sum register as operand A instead of port a.
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse: result valid.
REQ-011 SHALL have port: sum  output  WIDTH  registered result.
REQ-012 SHALL have port: cout  output  1  raw carry out of MSB (1 = no borrow when sub=1).
REQ-013 SHALL have port: V  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-014 SHALL have port: zero  output  1  high when sum == 0.

Function
REQ-015 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-016 SHALL, in IDLE with start=1 (cycle T), latch A (a, or sum if acc=1), B XOR {WIDTH{sub}}, set carry register to sub, clear bit index to 0, enter RUN.
REQ-017 SHALL, in IDLE with start=0, remain in IDLE, outputs unchanged.
REQ-018 SHALL, in RUN, process exactly one bit per cycle, LSB first, using a single 1-bit full-adder slice: sum bit i = A[i] ^ B'[i] ^ carry; carry <= majority(A[i], B'[i], carry).
REQ-019 SHALL stay in RUN for exactly WIDTH cycles (T+1..T+WIDTH), then enter DONE.
REQ-020 SHALL record carry into MSB when processing bit WIDTH-1; V = that carry XOR final carry.
REQ-021 SHALL assert done for exactly one cycle, in DONE (cycle T+WIDTH+1), then return to IDLE; latency start->done = WIDTH+1 cycles.
REQ-022 SHALL update sum, cout, V, zero only at the transition into DONE; they are held constant from DONE until the next operation's DONE.
REQ-023 SHALL ignore start while in RUN or DONE (no queuing, no restart, operands unchanged).
REQ-024 SHALL, with acc=1, use sum value as of cycle T (previous result), enabling back-to-back accumulation.
REQ-025 SHALL ignore changes on a, b, sub, acc after cycle T until the next accepted start.
REQ-026 SHALL wrap modulo 2^WIDTH; no saturation; overflow reported only via V and cout.
REQ-027 SHALL, for WIDTH=1, spend one RUN cycle; MSB and LSB coincide; V = sub XOR cout.

Reset
REQ-028 SHALL, when reset=1 at a rising edge, force state IDLE and busy=0, done=0, sum=0, cout=0, V=0, zero=1, internal operand/carry/index registers to 0.
REQ-029 SHALL let reset take priority over start and abort any operation in RUN or DONE with no done pulse.
REQ-030 SHALL accept start on the first cycle after reset deasserts.

Verification (WIDTH=4)
REQ-031 SHALL pass: start, sub=0, a=0111, b=0001 -> done at T+5; sum=1000, cout=0, V=1, zero=0; busy high T+1..T+5.
REQ-032 SHALL pass: sub=1, a=0011, b=0101 -> sum=1110, cout=0, V=0; then sub=1, a=0101, b=0011 -> sum=0010, cout=1, V=0.
REQ-033 SHALL pass: sub=1, a=1000, b=0001 -> sum=0111, cout=1, V=1; sub=0, a=1111, b=0001 -> sum=0000, cout=1, V=0, zero=1.
REQ-034 SHALL pass: result sum=0010, then start acc=1, sub=0, b=0011, a=1111 (ignored) -> sum=0101; then acc=1, sub=1, b=0110 -> sum=1111, V=0.
REQ-035 SHALL pass: start pulsed again at T+2 and a/b changed mid-RUN -> single done at T+5, result from cycle-T operands only.
REQ-036 SHALL pass: reset asserted at T+3 mid-RUN -> next cycle busy=0, done=0, sum=0, zero=1; no done pulse; new start then completes normally.
